cirno9_mem_arb: RTL and testbench

CIRNO9_MEM_ARB -- requirements
Module: cirno9_mem_arb

---
 rtl/cirno9_mem_arb_pkg.sv | 22 ++
 rtl/cirno9_mem_arb_if.sv | 45 ++++
 rtl/cirno9_mem_arb_rr_arb.sv | 39 +++
 rtl/cirno9_mem_arb.sv | 209 ++++++++++++++++++++
 tb/tb_cirno9_mem_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cirno9_mem_arb_pkg.sv
// Shared types and constants for the cirno9 memory arbiter.
package cirno9_mem_arb_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SRAM_ACC = 3'd1,
    ST_SRAM_RSP = 3'd2,
    ST_AXI_WAIT = 3'd3,
    ST_ERR_RSP  = 3'd4
  } state_t;

  // Arbitration policy selectors.
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cirno9_mem_arb_if.sv
// Requester, SRAM and AXI-adapter bus bundle for the cirno9 arbiter.
// slave  = arbiter view, master = environment (requesters + downstream) view.
interface cirno9_mem_arb_if #(
  parameter int NREQ = 3,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  // requester side
  logic [NREQ-1:0]        req_val;
  logic [NREQ*AW-1:0]     req_adr;
  logic [NREQ*DW-1:0]     req_wdat;
  logic [NREQ*DW/8-1:0]   req_wen;
  logic [NREQ-1:0]        req_ren;
  logic [NREQ-1:0]        req_rdy;
  logic [DW-1:0]          rsp_rdat;
  logic                   rsp_err;
  // SRAM side
  logic                   sram_val;
  logic                   sram_ren;
  logic [DW/8-1:0]        sram_wen;
  logic [AW-1:0]          sram_adr;
  logic [DW-1:0]          sram_wdat;
  logic [DW-1:0]          sram_rdat;
  // AXI master adapter side
  logic                   axm_val;
  logic [DW/8-1:0]        axm_wen;
  logic [AW-1:0]          axm_adr;
  logic [DW-1:0]          axm_wdat;
  logic                   axm_rdy;
  logic [DW-1:0]          axm_rdat;

  modport slave (
    input  req_val, req_adr, req_wdat, req_wen, req_ren, sram_rdat, axm_rdy, axm_rdat,
    output req_rdy, rsp_rdat, rsp_err,
    output sram_val, sram_ren, sram_wen, sram_adr, sram_wdat,
    output axm_val, axm_wen, axm_adr, axm_wdat
  );

  modport master (
    output req_val, req_adr, req_wdat, req_wen, req_ren, sram_rdat, axm_rdy, axm_rdat,
    input  req_rdy, rsp_rdat, rsp_err,
    input  sram_val, sram_ren, sram_wen, sram_adr, sram_wdat,
    input  axm_val, axm_wen, axm_adr, axm_wdat
  );
endinterface

// File: rtl/cirno9_mem_arb_rr_arb.sv
// Requester arbiter: round-robin after a pointer, or fixed lowest-index priority.
// Purely combinational; the caller owns the pointer register.
module cirno9_rr_arb
  import cirno9_mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            fixed_mode,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_val
);

  logic [IW-1:0] cand_s;

  // Pick the winner; loops walk from worst to best so the last hit is the winner.
  always_comb begin
    gnt_idx = '0;
    gnt_val = 1'b0;
    cand_s  = '0;
    if (fixed_mode) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        gnt_idx = req[i] ? IW'(i) : gnt_idx;
        gnt_val = gnt_val | req[i];
      end
    end else begin
      for (int off = NREQ; off >= 1; off--) begin
        cand_s  = IW'((int'(ptr) + off) % NREQ);
        gnt_idx = req[cand_s] ? cand_s : gnt_idx;
        gnt_val = gnt_val | req[cand_s];
      end
    end
    gnt = gnt_val ? (NREQ'(1'b1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/cirno9_mem_arb.sv
// cirno9 memory arbiter: grants one of NREQ requesters, decodes the address to
// SRAM, AXI adapter or error, runs the access and pulses a single completion.
module cirno9_mem_arb
  import cirno9_mem_arb_pkg::*;
#(
  parameter int          NREQ      = 3,
  parameter int          AW        = 32,
  parameter int          DW        = 32,
  parameter int          ARB_MODE  = 0,
  parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
  parameter logic [31:0] SRAM_MASK = 32'hFFFF_0000,
  parameter logic [31:0] AXI_BASE  = 32'h1000_0000,
  parameter logic [31:0] AXI_MASK  = 32'hF000_0000
) (
  input logic             clk,
  input logic             rst,
  cirno9_mem_arb_if.slave bus
);

  localparam int IW = idx_width(NREQ);
  localparam int BW = DW / 8;

  function automatic logic in_region(input logic [AW-1:0] a,
                                     input logic [AW-1:0] base,
                                     input logic [AW-1:0] mask);
    return (a & mask) == base;
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [BW-1:0]   wen_q, wen_d;
  logic            ren_q, ren_d;

  logic [NREQ-1:0] gnt_s;
  logic [IW-1:0]   gnt_idx_s;
  logic            gnt_val_s;
  logic [AW-1:0]   sel_adr_s;
  logic [DW-1:0]   sel_wdat_s;
  logic [BW-1:0]   sel_wen_s;
  logic            sel_ren_s;

  logic [NREQ-1:0] req_rdy_s;
  logic [DW-1:0]   rsp_rdat_s;
  logic            rsp_err_s;
  logic            sram_val_s, sram_ren_s;
  logic [BW-1:0]   sram_wen_s;
  logic [AW-1:0]   sram_adr_s;
  logic [DW-1:0]   sram_wdat_s;
  logic            axm_val_s;
  logic [BW-1:0]   axm_wen_s;
  logic [AW-1:0]   axm_adr_s;
  logic [DW-1:0]   axm_wdat_s;
  logic            is_write_s;

  cirno9_rr_arb #(.NREQ(NREQ)) u_arb (
    .req        (bus.req_val),
    .ptr        (ptr_q),
    .fixed_mode ((ARB_MODE == ARB_FIXED) ? 1'b1 : 1'b0),
    .gnt        (gnt_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_val    (gnt_val_s)
  );

  // One-hot AND-OR mux of the winning requester's fields.
  always_comb begin
    sel_adr_s  = '0;
    sel_wdat_s = '0;
    sel_wen_s  = '0;
    sel_ren_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_adr_s  = sel_adr_s  | (gnt_s[i] ? bus.req_adr[i*AW +: AW]  : '0);
      sel_wdat_s = sel_wdat_s | (gnt_s[i] ? bus.req_wdat[i*DW +: DW] : '0);
      sel_wen_s  = sel_wen_s  | (gnt_s[i] ? bus.req_wen[i*BW +: BW]  : '0);
      sel_ren_s  = sel_ren_s  | (gnt_s[i] & bus.req_ren[i]);
    end
  end

  // Next state: latch and decode on grant, then walk the access sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_val_s) begin
          idx_d  = gnt_idx_s;
          ptr_d  = gnt_idx_s;
          adr_d  = sel_adr_s;
          wdat_d = sel_wdat_s;
          wen_d  = sel_wen_s;
          ren_d  = sel_ren_s;
          // SRAM is checked first so it wins an overlapping decode.
          if (in_region(sel_adr_s, AW'(SRAM_BASE), AW'(SRAM_MASK))) begin
            state_d = ST_SRAM_ACC;
          end else if (in_region(sel_adr_s, AW'(AXI_BASE), AW'(AXI_MASK))) begin
            state_d = ST_AXI_WAIT;
          end else begin
            state_d = ST_ERR_RSP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SRAM_ACC: state_d = ST_SRAM_RSP;
      ST_SRAM_RSP: state_d = ST_IDLE;
      ST_AXI_WAIT: begin
        if (bus.axm_rdy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_AXI_WAIT;
        end
      end
      ST_ERR_RSP:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from the state and latched fields; idle buses read zero.
  always_comb begin
    is_write_s  = |wen_q;
    req_rdy_s   = '0;
    rsp_rdat_s  = '0;
    rsp_err_s   = 1'b0;
    sram_val_s  = 1'b0;
    sram_ren_s  = 1'b0;
    sram_wen_s  = '0;
    sram_adr_s  = '0;
    sram_wdat_s = '0;
    axm_val_s   = 1'b0;
    axm_wen_s   = '0;
    axm_adr_s   = '0;
    axm_wdat_s  = '0;
    case (state_q)
      ST_SRAM_ACC: begin
        sram_val_s  = 1'b1;
        sram_ren_s  = ren_q;
        sram_wen_s  = wen_q;
        sram_adr_s  = adr_q;
        sram_wdat_s = wdat_q;
      end
      ST_SRAM_RSP: begin
        req_rdy_s  = NREQ'(1'b1) << idx_q;
        rsp_rdat_s = is_write_s ? '0 : bus.sram_rdat;
      end
      ST_AXI_WAIT: begin
        axm_val_s  = 1'b1;
        axm_wen_s  = wen_q;
        axm_adr_s  = adr_q;
        axm_wdat_s = wdat_q;
        if (bus.axm_rdy) begin
          req_rdy_s  = NREQ'(1'b1) << idx_q;
          rsp_rdat_s = is_write_s ? '0 : bus.axm_rdat;
        end else begin
          req_rdy_s  = '0;
          rsp_rdat_s = '0;
        end
      end
      ST_ERR_RSP: begin
        req_rdy_s = NREQ'(1'b1) << idx_q;
        rsp_err_s = 1'b1;
      end
      default: begin
        req_rdy_s = '0;
      end
    endcase
  end

  assign bus.req_rdy   = req_rdy_s;
  assign bus.rsp_rdat  = rsp_rdat_s;
  assign bus.rsp_err   = rsp_err_s;
  assign bus.sram_val  = sram_val_s;
  assign bus.sram_ren  = sram_ren_s;
  assign bus.sram_wen  = sram_wen_s;
  assign bus.sram_adr  = sram_adr_s;
  assign bus.sram_wdat = sram_wdat_s;
  assign bus.axm_val   = axm_val_s;
  assign bus.axm_wen   = axm_wen_s;
  assign bus.axm_adr   = axm_adr_s;
  assign bus.axm_wdat  = axm_wdat_s;

  // State, pointer and latched request registers; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      idx_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      wen_q   <= '0;
      ren_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
    end
  end

endmodule

// File: tb/tb_cirno9_mem_arb.sv
// Scoreboard bench for cirno9_mem_arb: a round-robin instance and a
// fixed-priority instance share clock and reset.
module tb_cirno9_mem_arb;

  localparam logic [31:0] SRAM_KEY = 32'h5EAD_BEFF;
  localparam logic [31:0] AXI_KEY  = 32'hA5A5_0F0F;

  typedef struct {
    int          idx;
    logic [31:0] rdat;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cirno9_mem_arb_if #(.NREQ(3), .AW(32), .DW(32)) b0 ();
  cirno9_mem_arb_if #(.NREQ(3), .AW(32), .DW(32)) b1 ();

  cirno9_mem_arb #(.NREQ(3), .AW(32), .DW(32), .ARB_MODE(0)) dut_rr (.clk(clk), .rst(rst), .bus(b0));
  cirno9_mem_arb #(.NREQ(3), .AW(32), .DW(32), .ARB_MODE(1)) dut_fp (.clk(clk), .rst(rst), .bus(b1));

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          axi_lat = 5;
  int          axi_cnt = 0;
  logic        prev_sv0 = 1'b0, prev_sv1 = 1'b0;
  logic [31:0] prev_sa0 = 32'h0, prev_sa1 = 32'h0;

  // One clock: responders update just after the edge, outputs sampled at +2.
  task automatic step();
    @(posedge clk);
    #1;
    b0.sram_rdat = prev_sv0 ? (prev_sa0 ^ SRAM_KEY) : 32'h0;
    b1.sram_rdat = prev_sv1 ? (prev_sa1 ^ SRAM_KEY) : 32'h0;
    prev_sv0 = b0.sram_val; prev_sa0 = b0.sram_adr;
    prev_sv1 = b1.sram_val; prev_sa1 = b1.sram_adr;
    if (b0.axm_val) begin
      axi_cnt++;
      b0.axm_rdy  = (axi_cnt == axi_lat) ? 1'b1 : 1'b0;
      b0.axm_rdat = b0.axm_rdy ? (b0.axm_adr ^ AXI_KEY) : 32'h0;
    end else begin
      axi_cnt = 0;
      b0.axm_rdy = 1'b0;
      b0.axm_rdat = 32'h0;
    end
    #1;
  endtask

  task automatic load0(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic r);
    b0.req_adr[i*32 +: 32] = a;
    b0.req_wdat[i*32 +: 32] = d;
    b0.req_wen[i*4 +: 4] = w;
    b0.req_ren[i] = r;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    b0.req_val = 3'b000; b1.req_val = 3'b000;
    step(); step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.req_val = 3'b111; b1.req_val = 3'b111;
    step();
    n_cmp++;
    if ({b0.req_rdy, b0.rsp_err, b0.rsp_rdat, b0.sram_val, b0.sram_ren, b0.sram_wen,
         b0.sram_adr, b0.sram_wdat, b0.axm_val, b0.axm_wen, b0.axm_adr, b0.axm_wdat} !== '0) begin
      n_bad++; $display("FAIL reset_rr: outputs nonzero during reset, req_rdy=%b sram_val=%b axm_val=%b", b0.req_rdy, b0.sram_val, b0.axm_val);
    end
    n_cmp++;
    if ({b1.req_rdy, b1.rsp_err, b1.rsp_rdat, b1.sram_val, b1.axm_val} !== '0) begin
      n_bad++; $display("FAIL reset_fp: outputs nonzero during reset, req_rdy=%b", b1.req_rdy);
    end
    apply_reset();
  endtask

  task automatic test_sram_read();
    load0(0, 32'h8000_0010, 32'h0, 4'h0, 1'b1);
    sb.push_back('{0, 32'hDEAD_BEEF, 1'b0});
    b0.req_val = 3'b001;
    step();
    n_cmp++;
    if (b0.sram_val !== 1'b1 || b0.sram_ren !== 1'b1 || b0.sram_adr !== 32'h8000_0010 || b0.req_rdy !== 3'b000) begin
      n_bad++; $display("FAIL sram_c1: sram_val=%b ren=%b adr=%h req_rdy=%b, want 1 1 80000010 000", b0.sram_val, b0.sram_ren, b0.sram_adr, b0.req_rdy);
    end
    step();
    e = sb.pop_front();
    n_cmp++;
    if (b0.req_rdy !== 3'b001 || b0.sram_val !== 1'b0) begin
      n_bad++; $display("FAIL sram_c2: req_rdy=%b sram_val=%b, want 001 0", b0.req_rdy, b0.sram_val);
    end
    n_cmp++;
    if (b0.rsp_rdat !== e.rdat || b0.rsp_err !== e.err) begin
      n_bad++; $display("FAIL sram_rdat: got %h err %b, want %h err %b", b0.rsp_rdat, b0.rsp_err, e.rdat, e.err);
    end
    b0.req_val = 3'b000;
    step();
    n_cmp++;
    if (b0.req_rdy !== 3'b000 || b0.rsp_rdat !== 32'h0 || b0.sram_val !== 1'b0) begin
      n_bad++; $display("FAIL sram_c3: req_rdy=%b rdat=%h sram_val=%b, want idle", b0.req_rdy, b0.rsp_rdat, b0.sram_val);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] a [3];
    int grants = 0;
    int last = 0;
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'h8000_0100 + 32'(i * 16);
      load0(i, a[i], 32'h0, 4'h0, 1'b1);
    end
    sb.push_back('{0, a[0] ^ SRAM_KEY, 1'b0});
    sb.push_back('{1, a[1] ^ SRAM_KEY, 1'b0});
    sb.push_back('{2, a[2] ^ SRAM_KEY, 1'b0});
    sb.push_back('{0, a[0] ^ SRAM_KEY, 1'b0});
    b0.req_val = 3'b111;
    for (int c = 1; c <= 20 && grants < 4; c++) begin
      step();
      if (b0.req_rdy !== 3'b000) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL rr_extra: unexpected req_rdy=%b", b0.req_rdy);
        end else begin
          e = sb.pop_front();
          if (b0.req_rdy !== 3'(1 << e.idx) || b0.rsp_rdat !== e.rdat) begin
            n_bad++; $display("FAIL rr_grant%0d: req_rdy=%b rdat=%h, want %b %h", grants, b0.req_rdy, b0.rsp_rdat, 3'(1 << e.idx), e.rdat);
          end
        end
        n_cmp++;
        if (c - last !== ((grants == 0) ? 2 : 3)) begin
          n_bad++; $display("FAIL rr_spacing%0d: %0d cycles, want %0d", grants, c - last, (grants == 0) ? 2 : 3);
        end
        last = c;
        grants++;
        if (grants == 4) b0.req_val = 3'b000;
      end else begin
        n_cmp++;
        if (b0.rsp_rdat !== 32'h0) begin
          n_bad++; $display("FAIL rr_rdat_idle: rsp_rdat=%h with no req_rdy, want 0", b0.rsp_rdat);
        end
      end
    end
    n_cmp++;
    if (grants !== 4) begin
      n_bad++; $display("FAIL rr_timeout: %0d grants, want 4", grants);
    end
  endtask

  task automatic test_fixed_priority();
    int grants = 0;
    b1.req_adr[0 +: 32] = 32'h8000_0200; b1.req_adr[64 +: 32] = 32'h8000_0208;
    b1.req_ren = 3'b101;
    for (int k = 0; k < 4; k++) sb.push_back('{0, 32'h8000_0200 ^ SRAM_KEY, 1'b0});
    b1.req_val = 3'b101;
    for (int c = 1; c <= 16 && grants < 4; c++) begin
      step();
      if (b1.req_rdy !== 3'b000) begin
        e = sb.pop_front();
        n_cmp++;
        if (b1.req_rdy !== 3'(1 << e.idx) || b1.rsp_rdat !== e.rdat) begin
          n_bad++; $display("FAIL fp_grant%0d: req_rdy=%b rdat=%h, want %b %h", grants, b1.req_rdy, b1.rsp_rdat, 3'(1 << e.idx), e.rdat);
        end
        grants++;
      end else begin
        grants = grants;
      end
    end
    b1.req_val = 3'b000;
    n_cmp++;
    if (grants !== 4) begin
      n_bad++; $display("FAIL fp_timeout: %0d grants, want 4", grants);
    end
    step();
  endtask

  task automatic test_axi(input string nm, input int lat, input int idx,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    int nval = 0;
    int nrdy = 0;
    axi_lat = lat;
    load0(idx, a, d, w, (w == 4'h0) ? 1'b1 : 1'b0);
    sb.push_back('{idx, (w == 4'h0) ? (a ^ AXI_KEY) : 32'h0, 1'b0});
    b0.req_val = 3'(1 << idx);
    for (int c = 1; c <= 20 && nrdy == 0; c++) begin
      step();
      n_cmp++;
      if (b0.sram_val !== 1'b0) begin
        n_bad++; $display("FAIL %s_no_sram: sram_val=%b, want 0", nm, b0.sram_val);
      end
      if (b0.axm_val) begin
        nval++;
        n_cmp++;
        if (b0.axm_adr !== a || b0.axm_wen !== w || b0.axm_wdat !== d) begin
          n_bad++; $display("FAIL %s_fields: adr=%h wen=%h wdat=%h, want %h %h %h", nm, b0.axm_adr, b0.axm_wen, b0.axm_wdat, a, w, d);
        end
      end
      if (b0.req_rdy !== 3'b000) begin
        nrdy++;
        e = sb.pop_front();
        n_cmp++;
        if (b0.req_rdy !== 3'(1 << e.idx) || b0.rsp_rdat !== e.rdat || b0.rsp_err !== e.err || b0.axm_val !== 1'b1) begin
          n_bad++; $display("FAIL %s_rsp: req_rdy=%b rdat=%h err=%b axm_val=%b, want %b %h %b 1", nm, b0.req_rdy, b0.rsp_rdat, b0.rsp_err, b0.axm_val, 3'(1 << e.idx), e.rdat, e.err);
        end
        b0.req_val = 3'b000;
      end
    end
    n_cmp++;
    if (nval !== lat || nrdy !== 1) begin
      n_bad++; $display("FAIL %s_count: axm_val cycles=%0d rdy=%0d, want %0d 1", nm, nval, nrdy, lat);
    end
    step();
    n_cmp++;
    if (b0.axm_val !== 1'b0 || b0.req_rdy !== 3'b000) begin
      n_bad++; $display("FAIL %s_after: axm_val=%b req_rdy=%b, want 0 000", nm, b0.axm_val, b0.req_rdy);
    end
  endtask

  task automatic test_decode_error();
    load0(1, 32'h4000_0000, 32'h0, 4'h0, 1'b1);
    sb.push_back('{1, 32'h0, 1'b1});
    b0.req_val = 3'b010;
    step();
    e = sb.pop_front();
    n_cmp++;
    if (b0.req_rdy !== 3'(1 << e.idx) || b0.rsp_err !== e.err || b0.rsp_rdat !== e.rdat) begin
      n_bad++; $display("FAIL err_rsp: req_rdy=%b err=%b rdat=%h, want %b %b %h", b0.req_rdy, b0.rsp_err, b0.rsp_rdat, 3'(1 << e.idx), e.err, e.rdat);
    end
    n_cmp++;
    if (b0.sram_val !== 1'b0 || b0.axm_val !== 1'b0) begin
      n_bad++; $display("FAIL err_strobe: sram_val=%b axm_val=%b, want 0 0", b0.sram_val, b0.axm_val);
    end
    b0.req_val = 3'b000;
    step();
    n_cmp++;
    if (b0.rsp_err !== 1'b0 || b0.req_rdy !== 3'b000) begin
      n_bad++; $display("FAIL err_after: err=%b req_rdy=%b, want 0 000", b0.rsp_err, b0.req_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    load0(0, 32'h8000_0020, 32'hCAFE_0001, 4'h3, 1'b0);
    sb.push_back('{0, 32'h0, 1'b0});
    b0.req_val = 3'b001;
    step();
    n_cmp++;
    if (b0.sram_val !== 1'b1 || b0.sram_wen !== 4'h3 || b0.sram_wdat !== 32'hCAFE_0001 || b0.sram_ren !== 1'b0) begin
      n_bad++; $display("FAIL b2b_write: val=%b wen=%h wdat=%h ren=%b, want 1 3 cafe0001 0", b0.sram_val, b0.sram_wen, b0.sram_wdat, b0.sram_ren);
    end
    load0(2, 32'h0000_0100, 32'h0, 4'h0, 1'b1);
    sb.push_back('{2, 32'h0, 1'b1});
    b0.req_val = 3'b101;
    for (int c = 2; c <= 12 && seen < 2; c++) begin
      step();
      if (b0.req_rdy !== 3'b000) begin
        e = sb.pop_front();
        n_cmp++;
        if (b0.req_rdy !== 3'(1 << e.idx) || b0.rsp_rdat !== e.rdat || b0.rsp_err !== e.err) begin
          n_bad++; $display("FAIL b2b_rsp%0d: req_rdy=%b rdat=%h err=%b, want %b %h %b", seen, b0.req_rdy, b0.rsp_rdat, b0.rsp_err, 3'(1 << e.idx), e.rdat, e.err);
        end
        b0.req_val = b0.req_val & ~b0.req_rdy;
        seen++;
      end else begin
        seen = seen;
      end
    end
    n_cmp++;
    if (seen !== 2) begin
      n_bad++; $display("FAIL b2b_timeout: %0d completions, want 2", seen);
    end
    b0.req_val = 3'b000;
    step();
  endtask

  task automatic test_reset_axi();
    int seen = 0;
    axi_lat = 1000;
    load0(1, 32'h1000_0008, 32'h0, 4'h0, 1'b1);
    b0.req_val = 3'b010;
    step(); step();
    n_cmp++;
    if (b0.axm_val !== 1'b1) begin
      n_bad++; $display("FAIL rsta_wait: axm_val=%b, want 1", b0.axm_val);
    end
    rst = 1'b1;
    b0.req_val = 3'b000;
    step();
    n_cmp++;
    if (b0.axm_val !== 1'b0 || b0.req_rdy !== 3'b000) begin
      n_bad++; $display("FAIL rsta_abandon: axm_val=%b req_rdy=%b, want 0 000", b0.axm_val, b0.req_rdy);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) load0(i, 32'h8000_0300 + 32'(i * 4), 32'h0, 4'h0, 1'b1);
    sb.push_back('{0, 32'h8000_0300 ^ SRAM_KEY, 1'b0});
    b0.req_val = 3'b111;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      step();
      if (b0.req_rdy !== 3'b000) begin
        e = sb.pop_front();
        n_cmp++;
        if (b0.req_rdy !== 3'(1 << e.idx) || b0.rsp_rdat !== e.rdat) begin
          n_bad++; $display("FAIL rsta_next: req_rdy=%b rdat=%h, want %b %h", b0.req_rdy, b0.rsp_rdat, 3'(1 << e.idx), e.rdat);
        end
        b0.req_val = 3'b000;
        seen++;
      end else begin
        seen = seen;
      end
    end
    n_cmp++;
    if (seen !== 1) begin
      n_bad++; $display("FAIL rsta_timeout: %0d completions, want 1", seen);
    end
  endtask

  initial begin
    b0.req_val = '0; b0.req_adr = '0; b0.req_wdat = '0; b0.req_wen = '0; b0.req_ren = '0;
    b0.sram_rdat = '0; b0.axm_rdy = 1'b0; b0.axm_rdat = '0;
    b1.req_val = '0; b1.req_adr = '0; b1.req_wdat = '0; b1.req_wen = '0; b1.req_ren = '0;
    b1.sram_rdat = '0; b1.axm_rdy = 1'b0; b1.axm_rdat = '0;
    test_reset();
    test_sram_read();
    apply_reset();
    test_round_robin();
    test_fixed_priority();
    test_axi("axi_wr", 5, 0, 32'h1000_0004, 32'h1234_5678, 4'hF);
    test_axi("axi_rd", 2, 2, 32'h1000_0040, 32'h0, 4'h0);
    test_decode_error();
    test_back_to_back();
    test_reset_axi();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL sb_leftover: %0d expected responses never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
